// File: rtl/mvm_controller.sv
// mvm_controller: sequencing controller for the NxN matrix-vector multiplier
// datapath. Loads X (row-major) then A from one valid/ready input stream,
// runs N multiply-accumulate passes (one per row of Y = X*A), then streams Y
// out through a valid/ready output port.
//
// Optional feature macro: MVM_CTRL_KEEP_X_EN
//   When defined, adds input keep_x (sampled with start); keep_x=1 skips the
//   X load and reuses the previously loaded matrix.
//
// Ports:
//   clk, reset_n          clock, synchronous active-low reset
//   start [, keep_x]      job request (IDLE only)
//   busy, done            job status; done pulses on the last Y handshake
//   in_valid / in_ready   input stream handshake (payload on datapath data_in)
//   out_valid / out_ready output stream handshake (payload on datapath data_out)
//   addr_x, wr_en_x       X memory control
//   addr_a, wr_en_a       A memory control
//   addr_y, wr_en_y       Y memory control
//   clear_acc             accumulator clear
module mvm_controller #(
  parameter int N   = 3,
  parameter int AXW = 4,
  parameter int AVW = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           start,
`ifdef MVM_CTRL_KEEP_X_EN
  input  logic           keep_x,
`endif
  output logic           busy,
  output logic           done,
  input  logic           in_valid,
  output logic           in_ready,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [AXW-1:0] addr_x,
  output logic           wr_en_x,
  output logic [AVW-1:0] addr_a,
  output logic           wr_en_a,
  output logic [AVW-1:0] addr_y,
  output logic           wr_en_y,
  output logic           clear_acc
);

  typedef enum logic [2:0] {
    IDLE, LOAD_X, LOAD_A, CLEAR, MAC, WRITE_Y, OUTPUT
  } state_t;

  localparam logic [AXW-1:0] LAST_X = AXW'(N * N - 1);
  localparam logic [AXW-1:0] LAST_V = AXW'(N - 1);
  localparam logic [AVW-1:0] LAST_K = AVW'(N - 1);

  state_t         state, state_nx;
  logic [AXW-1:0] i, i_nx;
  logic [AVW-1:0] k, k_nx;
  logic           keep_sel;

`ifdef MVM_CTRL_KEEP_X_EN
  assign keep_sel = keep_x;
`else
  assign keep_sel = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state <= IDLE;
      i     <= '0;
      k     <= '0;
    end else begin
      state <= state_nx;
      i     <= i_nx;
      k     <= k_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    i_nx      = i;
    k_nx      = k;
    busy      = (state != IDLE);
    done      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    addr_x    = '0;
    wr_en_x   = 1'b0;
    addr_a    = '0;
    wr_en_a   = 1'b0;
    addr_y    = '0;
    wr_en_y   = 1'b0;
    clear_acc = 1'b0;

    case (state)
      IDLE: begin
        clear_acc = 1'b1;
        if (start) begin
          i_nx     = '0;
          state_nx = keep_sel ? LOAD_A : LOAD_X;
        end
      end

      LOAD_X: begin
        in_ready = 1'b1;
        addr_x   = i;
        wr_en_x  = in_valid;
        if (in_valid) begin
          if (i == LAST_X) begin
            i_nx     = '0;
            state_nx = LOAD_A;
          end else begin
            i_nx = i + 1'b1;
          end
        end
      end

      LOAD_A: begin
        in_ready = 1'b1;
        addr_a   = i[AVW-1:0];
        wr_en_a  = in_valid;
        if (in_valid) begin
          if (i == LAST_V) begin
            i_nx     = '0;
            state_nx = CLEAR;
          end else begin
            i_nx = i + 1'b1;
          end
        end
      end

      CLEAR: begin
        clear_acc = 1'b1;
        k_nx      = '0;
        state_nx  = MAC;
      end

      MAC: begin
        // i holds the row being computed; k walks the columns.
        addr_x = i * AXW'(N) + AXW'(k);
        addr_a = k;
        if (k == LAST_K) begin
          k_nx     = '0;
          state_nx = WRITE_Y;
        end else begin
          k_nx = k + 1'b1;
        end
      end

      WRITE_Y: begin
        wr_en_y = 1'b1;
        addr_y  = i[AVW-1:0];
        if (i < LAST_V) begin
          i_nx     = i + 1'b1;
          state_nx = CLEAR;
        end else begin
          i_nx     = '0;
          state_nx = OUTPUT;
        end
      end

      OUTPUT: begin
        out_valid = 1'b1;
        addr_y    = i[AVW-1:0];
        if (out_ready) begin
          if (i == LAST_V) begin
            done     = 1'b1;
            i_nx     = '0;
            state_nx = IDLE;
          end else begin
            i_nx = i + 1'b1;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mvm_controller.sv
// Testbench for mvm_controller: a behavioural 3x3 datapath harness, a
// table of directed jobs, randomized jobs checked against a plain
// arithmetic Y = X*A model, and hand-written reset / stall sequences.
module tb_mvm_controller;

  logic              clk;
  logic              reset_n;
  logic              start;
`ifdef MVM_CTRL_KEEP_X_EN
  logic              keep_x;
`endif
  logic              busy, done;
  logic              in_valid, in_ready;
  logic              out_valid, out_ready;
  logic [3:0]        addr_x;
  logic              wr_en_x;
  logic [1:0]        addr_a, addr_y;
  logic              wr_en_a, wr_en_y;
  logic              clear_acc;
  logic signed [7:0]  data_in;
  logic signed [15:0] data_out;

  int checks = 0;
  int errors = 0;

  mvm_controller #(.N(3), .AXW(4), .AVW(2)) dut (
    .clk(clk), .reset_n(reset_n), .start(start),
`ifdef MVM_CTRL_KEEP_X_EN
    .keep_x(keep_x),
`endif
    .busy(busy), .done(done),
    .in_valid(in_valid), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .addr_x(addr_x), .wr_en_x(wr_en_x),
    .addr_a(addr_a), .wr_en_a(wr_en_a),
    .addr_y(addr_y), .wr_en_y(wr_en_y),
    .clear_acc(clear_acc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural datapath: combinational reads, clocked writes/accumulate.
  logic signed [7:0]  xm [16];
  logic signed [7:0]  am [4];
  logic signed [15:0] ym [4];
  logic signed [15:0] acc;

  always_ff @(posedge clk) begin
    if (wr_en_x) xm[addr_x] <= data_in;
    if (wr_en_a) am[addr_a] <= data_in;
    if (wr_en_y) ym[addr_y] <= acc;
    acc <= clear_acc ? 16'sd0 : acc + xm[addr_x] * am[addr_a];
  end
  assign data_out = ym[addr_y];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Current job operands and expected result.
  int jx [9];
  int ja [3];
  int jy [3];

  function automatic void model();
    for (int r = 0; r < 3; r++) begin
      int sum;
      logic signed [15:0] t;
      sum = 0;
      for (int c = 0; c < 3; c++) sum += jx[r*3+c] * ja[c];
      t = sum[15:0];
      jy[r] = int'(t);
    end
  endfunction

  // Runs one job using jx/ja, compares the output stream against jy.
  // gap: drop in_valid 2 cycles after every 2nd beat; stall_at: element
  // index at which out_ready is held low 3 cycles; rnd: random handshakes.
  task automatic run_job(input bit gap, input bit kx, input int stall_at, input bit rnd);
    int s [12];
    int total, beat, gapc, ny, ndone, donec, lastc, nwx, nwa, nhs, stallc, cyc;
    int held;
    bit stalling;
    total = kx ? 3 : 12;
    if (kx) for (int n = 0; n < 3; n++) s[n] = ja[n];
    else begin
      for (int n = 0; n < 9; n++) s[n] = jx[n];
      for (int n = 0; n < 3; n++) s[9+n] = ja[n];
    end
    beat = 0; gapc = 0; ny = 0; ndone = 0; donec = -1; lastc = -2;
    nwx = 0; nwa = 0; nhs = 0; stallc = 0; cyc = 0; held = 0;
    while (ny < 3 && cyc < 400) begin
      @(negedge clk);
      cyc++;
      // extra start pulses at 6 and 20 land while busy and must be ignored
      start = (cyc == 1 || cyc == 6 || cyc == 20);
`ifdef MVM_CTRL_KEEP_X_EN
      keep_x = kx;
`endif
      if (rnd) in_valid = (beat < total) && ($urandom_range(0, 2) != 0);
      else     in_valid = (beat < total) && (gapc == 0);
      data_in = in_valid ? 8'(s[beat]) : 8'($urandom);
      stalling = (ny == stall_at) && (stallc < 3);
      out_ready = rnd ? 1'($urandom_range(0, 1)) : !stalling;
      #1;
      if (wr_en_x) nwx++;
      if (wr_en_a) nwa++;
      if (done) begin ndone++; donec = cyc; end
      if (stalling && !rnd) begin
        chk("stall_out_valid", int'(out_valid), 1);
        chk("stall_addr_y", int'(addr_y), stall_at);
        if (stallc == 0) held = int'(data_out);
        else chk("stall_data_stable", int'(data_out), held);
        stallc++;
      end
      if (in_valid && in_ready) begin
        nhs++;
        beat++;
        if (gap && (beat % 2 == 0)) gapc = 2;
      end else if (gapc > 0) gapc--;
      if (out_valid && out_ready) begin
        chk("out_addr_y", int'(addr_y), ny);
        chk($sformatf("y[%0d]", ny), int'(data_out), jy[ny]);
        ny++;
        lastc = cyc;
      end
    end
    chk("job_complete", ny, 3);
    chk("done_pulses", ndone, 1);
    chk("done_on_last_handshake", donec, lastc);
    if (!gap && !rnd && stall_at < 0) chk("done_cycle", donec, kx ? 22 : 31);
    chk("wr_en_x_count", nwx, kx ? 0 : 9);
    chk("wr_en_a_count", nwa, 3);
    chk("in_handshakes", nhs, total);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    #1;
    chk("idle_after_job", int'(busy), 0);
  endtask

  typedef struct {
    int  x [9];
    int  a [3];
    bit  gap;
    int  y [3];
  } vec_t;

  vec_t vt [3];

  initial begin
    vt[0].x = '{1, 2, 3, 4, 5, 6, 7, 8, 9};
    vt[0].a = '{1, 2, 3};
    vt[0].gap = 1'b0;
    vt[0].y = '{14, 32, 50};
    vt[1].x = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    vt[1].a = '{-1, 5, 7};
    vt[1].gap = 1'b1;
    vt[1].y = '{-1, 5, 7};
    vt[2].x = '{-128, -128, -128, -128, -128, -128, -128, -128, -128};
    vt[2].a = '{-128, -128, -128};
    vt[2].gap = 1'b0;
    vt[2].y = '{-16384, -16384, -16384};

    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0;
`ifdef MVM_CTRL_KEEP_X_EN
    keep_x = 1'b0;
`endif
    repeat (3) @(negedge clk);
    start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_wr_en", int'({wr_en_x, wr_en_a, wr_en_y}), 0);
    chk("rst_addr", int'({addr_x, addr_a, addr_y}), 0);
    chk("rst_clear_acc", int'(clear_acc), 1);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    reset_n = 1'b1;
    @(negedge clk);

    // Directed table jobs.
    for (int t = 0; t < 3; t++) begin
      jx = vt[t].x; ja = vt[t].a; jy = vt[t].y;
      run_job(vt[t].gap, 1'b0, -1, 1'b0);
    end

    // Output back-pressure on element 1.
    jx = vt[0].x; ja = vt[0].a; jy = vt[0].y;
    run_job(1'b0, 1'b0, 1, 1'b0);

`ifdef MVM_CTRL_KEEP_X_EN
    // X = 1..9 is still loaded from the previous job.
    ja = '{0, 0, 1}; jy = '{3, 6, 9};
    run_job(1'b0, 1'b1, -1, 1'b0);
`endif

    // Reset during MAC of row 1 (cycle 21: row 1, column 1).
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      start = (c == 1);
      in_valid = 1'b1;
      data_in = 8'(c);
      out_ready = 1'b1;
    end
    #1;
    chk("mac_r1_addr_x", int'(addr_x), 4);
    chk("mac_clear_acc", int'(clear_acc), 0);
    chk("mac_in_ready", int'(in_ready), 0);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1; in_valid = 1'b0; start = 1'b0;
    #1;
    chk("abort_busy", int'(busy), 0);
    chk("abort_clear_acc", int'(clear_acc), 1);
    chk("abort_in_ready", int'(in_ready), 0);
    chk("abort_addr_x", int'(addr_x), 0);
    jx = vt[0].x; ja = vt[0].a; jy = vt[0].y;
    run_job(1'b0, 1'b0, -1, 1'b0);

    // Randomized jobs against the arithmetic model.
    for (int r = 0; r < 6; r++) begin
      for (int n = 0; n < 9; n++) jx[n] = $urandom_range(0, 255) - 128;
      for (int n = 0; n < 3; n++) ja[n] = $urandom_range(0, 255) - 128;
      model();
      run_job(1'b0, 1'b0, -1, 1'b1);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
